prio_encoder_latch: RTL

- Parametrised, clocked successor to the 7-input combinational priority encoder in the display project.
- Accepts N_IN active-low request lines, typically from buttons or switches. Synchronises and debounces the whole vector, then encodes the highest active index into registered outputs.
- Adds a latch mode that captures the first request until it is cleared, plus a one-cycle change-event pulse.
- Sits between board inputs and the 7-segment display driver.

---
 rtl/prio_enc_pkg.sv | 18 +
 rtl/sync_debounce.sv | 54 +++++
 rtl/prio_encoder_latch.sv | 100 ++++++++++
 3 files changed

// File: rtl/prio_enc_pkg.sv
// Shared types, defaults and width helpers for the clocked priority encoder.
package prio_enc_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      LATCHED = 1'b1
   } state_t;

   // A one-bit minimum keeps degenerate (<=2) ranges representable.
   function automatic int unsigned clog2_safe(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned N_IN_DEF       = 8;
   localparam int unsigned DEB_CYCLES_DEF = 4;
   localparam int unsigned DEB_CNT_W      = clog2_safe(DEB_CYCLES_DEF);

endpackage

// File: rtl/sync_debounce.sv
// Multi-stage synchroniser followed by a whole-vector debouncer on the request lines.
module sync_debounce
   import prio_enc_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam int unsigned      CNT_W    = clog2_safe(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  s;
   logic [WIDTH-1:0]                  s_prev;
   logic [WIDTH-1:0]                  f;
   logic [CNT_W-1:0]                  cnt;
   logic [CNT_W-1:0]                  cnt_nxt;

   assign s    = sync_q[SYNC_STAGES-1];
   assign dout = f;

   // Counter value is "cycles s has held" minus one; f loads on the edge it hits the limit.
   always_comb begin
      cnt_nxt = cnt;
      if (s != s_prev) begin
         cnt_nxt = '0;
      end else if (cnt != CNT_LAST) begin
         cnt_nxt = cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         s_prev <= '1;
         f      <= '1;
         cnt    <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         s_prev <= s;
         cnt    <= cnt_nxt;
         if (cnt_nxt == CNT_LAST) begin
            f <= s;
         end
      end
   end

endmodule

// File: rtl/prio_encoder_latch.sv
// Debounced active-low priority encoder with live/latch modes, cascade enable and change pulse.
module prio_encoder_latch
   import prio_enc_pkg::*;
#(
   parameter int unsigned N_IN        = N_IN_DEF,
   parameter int unsigned W_OUT       = clog2_safe(N_IN),
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             n_en,
   input  logic [N_IN-1:0]  n_din,
   input  logic             mode,
   input  logic             clr,
   output logic [W_OUT-1:0] code,
   output logic             gs,
   output logic             eo,
   output logic             new_evt
);

   logic [N_IN-1:0]  f;
   logic [W_OUT-1:0] comb_idx;
   logic             comb_gs;
   state_t           state;
   state_t           state_n;
   logic [W_OUT-1:0] code_n;
   logic             gs_n;
   logic             eo_n;

   sync_debounce #(
      .WIDTH       (N_IN),
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
   ) u_sync_debounce (
      .clk  (clk),
      .rst  (rst),
      .din  (n_din),
      .dout (f)
   );

   always_comb begin
      comb_idx = '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         if (!f[i]) begin
            comb_idx = W_OUT'(i);
         end
      end
      comb_gs = ~&f;
   end

   always_comb begin
      state_n = state;
      code_n  = code;
      gs_n    = gs;
      eo_n    = eo;
      if (n_en) begin
         state_n = IDLE;
         code_n  = '0;
         gs_n    = 1'b0;
         eo_n    = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               code_n = comb_idx;
               gs_n   = comb_gs;
               eo_n   = ~comb_gs;
               if (mode && comb_gs) begin
                  state_n = LATCHED;
               end
            end
            LATCHED: begin
               // Outputs stay frozen through the release edge; IDLE re-encodes on the next one.
               eo_n = 1'b0;
               if (clr || !mode) begin
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         code    <= '0;
         gs      <= 1'b0;
         eo      <= 1'b0;
         new_evt <= 1'b0;
      end else begin
         state   <= state_n;
         code    <= code_n;
         gs      <= gs_n;
         eo      <= eo_n;
         new_evt <= ({gs_n, code_n} != {gs, code});
      end
   end

endmodule
